pipe_hazard_seq_ctrl: RTL
=========================

# pipe_hazard_seq_ctrl

Central stall/flush controller for the 5-stage pipeline, including the multi-cycle LM/SM micro-op sequencer. It sits beside the ID stage. Each cycle it drives the `enable` and flush/bubble controls of the PC register, the IF/ID register and the ID/EX register from four inputs: load-use hazards, EX-stage redirects, memory stalls and LM/SM decode. While an LM/SM instruction is held in ID, it expands it into one ID/EX micro-op per set mask bit.

## Interface
- Parameters: none.
- Reset: one clock. `rst` is asynchronous, active-low.
- Ports:
  - `clk` — in, 1 — pipeline clock.
  - `rst` — in, 1 — asynchronous reset, active-low.
  - `id_valid` — in, 1 — the IF/ID register holds a real instruction.
  - `id_instr` — in, 16 — ID instruction. `[15:12]` opcode (LM=4'b0110, SM=4'b0111); `[7:0]` register mask.
  - `id_rs1`, `id_rs2` — in, 3 each — ID source registers.
  - `id_rs1_used`, `id_rs2_used` — in, 1 each — the source is actually read.
  - `ex_is_load` — in, 1 — the EX-stage op is a load.
  - `ex_rd` — in, 3 — EX-stage destination register.
  - `ex_redirect` — in, 1 — branch/jump resolved taken in EX.
  - `mem_stall` — in, 1 — data memory busy; whole front end must freeze.
  - `pc_en`, `if_id_en`, `id_ex_en` — out, 1 each — register enables.
  - `if_id_flush`, `id_ex_flush` — out, 1 each — load a NOP/bubble this edge.
  - `seq_active` — out, 1 — the ID/EX payload this cycle is an LM/SM micro-op.
  - `seq_rf_addr` — out, 3 — register for this micro-op.
  - `seq_offset` — out, 3 — word offset from base RA (0..7).
  - `seq_is_store` — out, 1 — the micro-op is SM (otherwise LM).
  - `seq_last` — out, 1 — final micro-op of the instruction.
  - `illegal_instr` — out, 1 — one-cycle pulse on an unsupported opcode.

## Operation
- All outputs are combinational from state plus inputs. State registers are `st` (IDLE/SEQ), `rem_mask[7:0]`, `offset[2:0]` and `is_store`.
- Default in IDLE with no event: all enables are 1 and all flushes are 0.
- Events are evaluated in strict priority order:
  1. `mem_stall`: all enables 0, all flushes 0. State is held. `ex_redirect` is ignored, because EX re-presents it.
  2. `ex_redirect`: `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1. The sequencer aborts: `st`→IDLE, `rem_mask`→0, `offset`→0.
  3. Load-use: `ex_is_load` and the register matches a used ID source. In IDLE: `pc_en`=`if_id_en`=0 and `id_ex_flush`=1 (one bubble); state is held. The LM/SM base RA (`id_rs1`) is checked the same way before a sequence starts. In SEQ with SM: a match of `ex_rd` against the current `seq_rf_addr` gives one bubble, and the counter/mask are held.
  4. LM/SM start (IDLE, `id_valid`, opcode LM or SM):
     - Mask ≠ 0: emit the micro-op for the lowest set bit. Bit i maps to Ri, processed in ascending order. `seq_offset`=0.
     - More bits remain: `pc_en`=`if_id_en`=0, `rem_mask` ← mask with the emitted bit cleared, `offset`←1, `st`→SEQ.
     - Exactly one bit set: `seq_last`=1 and the state stays IDLE (no stall).
     - Mask = 0: `id_ex_flush`=1 (the instruction becomes a NOP), no stall.
- SEQ, each cycle:
  - Emit the lowest set bit of `rem_mask`, with `seq_offset`=`offset`, `seq_active`=1 and `id_ex_en`=1.
  - Clear that bit and increment `offset`.
  - If it was the last bit: `seq_last`=1, `pc_en`=`if_id_en`=1 and `if_id_flush`=1 (the consumed LM/SM leaves ID), then `st`→IDLE.
  - Otherwise `pc_en`=`if_id_en`=0.
- `offset` never wraps: at most 8 micro-ops, so values 0..7.

## Timing
- Stall and flush decisions have zero latency: they act on the same clock edge.
- An instruction with N set mask bits occupies ID for N cycles and adds N−1 front-end stall cycles.
- Each load-use hazard costs exactly 1 bubble.
- Reset (`rst`=0, asynchronous):
  - `st`=IDLE, `rem_mask`=0, `offset`=0, `is_store`=0.
  - While `rst` is low, all enables and flushes are 0 and all `seq_*` outputs and `illegal_instr` are 0.
- Reset mid-sequence discards the remaining micro-ops.
- A redirect in the same cycle as the final micro-op still flushes ID/EX: that micro-op is lost by design, because it is younger than the branch.

## Configuration
- `PIPE_CTRL_LMSM_EN` defined: full LM/SM sequencer as described above.
- `PIPE_CTRL_LMSM_EN` undefined: no SEQ state or mask/offset registers.
  - LM/SM opcodes give `id_ex_flush`=1 and an `illegal_instr` pulse, with no stall.
  - `seq_*` outputs are tied to 0.

## Structure
- Shared package `pipe_pkg`: opcode constants `OP_LM`/`OP_SM`, the `seq_state_t` enum {IDLE, SEQ}, and register-index width `RF_AW`=3.
- One sub-module, `lowest_set_bit8`: a combinational 8-bit priority encoder giving index and one-hot bit, plus a `one_left` flag.

## Test plan
- LM with mask 8'b00100101, no hazards → micro-ops R0/off0, R2/off1, R5/off2. `pc_en`=0 for 2 cycles. `seq_last` high on R5, with `if_id_flush`=1 that cycle.
- SM with mask 8'b10000000 → one micro-op R7/off0 with `seq_last`=1, no stall, `seq_is_store`=1.
- `ex_is_load`, `ex_rd`=3, ADD in ID with `id_rs2`=3 and `id_rs2_used`=1 → exactly one cycle of `pc_en`=`if_id_en`=0 with `id_ex_flush`=1, then normal flow.
- `ex_redirect` during the 2nd micro-op of an 8-bit-mask LM → both flushes=1 that cycle, `seq_active`=0 on the next cycle, state IDLE.
- `mem_stall` held 3 cycles mid-SEQ → all enables 0 and `seq_offset` constant; the sequence resumes at the same register.
- `rst` pulsed low mid-SEQ, and the build without `PIPE_CTRL_LMSM_EN` given LM → on reset, all outputs 0 and state IDLE. Without the macro, LM yields one `illegal_instr` pulse plus `id_ex_flush`=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcode, state and register-index definitions for the pipeline controller
package pipe_pkg;

    localparam int RF_AW = 3;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/lowest_set_bit8.sv
// rtl/lowest_set_bit8.sv - 8-bit lowest-set-bit priority encoder with single-bit-remaining flag
module lowest_set_bit8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic [7:0] onehot,
    output logic       one_left
);

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = i[2:0];
        end
    end

    assign onehot   = mask & (~mask + 8'd1);
    assign one_left = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/pipe_hazard_seq_ctrl.sv
// rtl/pipe_hazard_seq_ctrl.sv - stall/flush controller with LM/SM micro-op sequencer (PIPE_CTRL_LMSM_EN)
module pipe_hazard_seq_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic [RF_AW-1:0] id_rs1,
    input  logic [RF_AW-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_is_load,
    input  logic [RF_AW-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             seq_active,
    output logic [RF_AW-1:0] seq_rf_addr,
    output logic [2:0]       seq_offset,
    output logic             seq_is_store,
    output logic             seq_last,
    output logic             illegal_instr
);

    logic [3:0] opcode;
    logic       is_lmsm;
    logic       src_hit;
    logic [7:0] enc_in;
    logic [2:0] lsb_idx;
    logic [7:0] lsb_bit;
    logic       lsb_one;

    assign opcode  = id_instr[15:12];
    assign is_lmsm = id_valid && ((opcode == OP_LM) || (opcode == OP_SM));
    assign src_hit = ex_is_load && id_valid &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

    lowest_set_bit8 u_lsb (
        .mask     (enc_in),
        .idx      (lsb_idx),
        .onehot   (lsb_bit),
        .one_left (lsb_one)
    );

`ifdef PIPE_CTRL_LMSM_EN

    seq_state_t st, st_nx;
    logic [7:0] rem_mask, rem_nx;
    logic [2:0] offset, off_nx;
    logic       is_store, is_store_nx;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^id_instr[11:8];
    assign enc_in = (st == SEQ) ? rem_mask : id_instr[7:0];

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        seq_active    = 1'b0;
        seq_rf_addr   = '0;
        seq_offset    = 3'd0;
        seq_is_store  = 1'b0;
        seq_last      = 1'b0;
        illegal_instr = 1'b0;
        st_nx         = st;
        rem_nx        = rem_mask;
        off_nx        = offset;
        is_store_nx   = is_store;

        if (!rst) begin
            st_nx = IDLE;
        end else if (mem_stall) begin
            // Frozen: keep presenting the pending micro-op so it is visibly unchanged.
            if (st == SEQ) begin
                seq_active   = 1'b1;
                seq_rf_addr  = lsb_idx;
                seq_offset   = offset;
                seq_is_store = is_store;
                seq_last     = lsb_one;
            end
        end else if (ex_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            st_nx       = IDLE;
            rem_nx      = 8'd0;
            off_nx      = 3'd0;
        end else if (st == IDLE) begin
            if (src_hit || (is_lmsm && ex_is_load && (id_rs1 == ex_rd))) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
                id_ex_en = 1'b1;
                if (is_lmsm) begin
                    if (id_instr[7:0] == 8'd0) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        seq_active   = 1'b1;
                        seq_rf_addr  = lsb_idx;
                        seq_offset   = 3'd0;
                        seq_is_store = (opcode == OP_SM);
                        seq_last     = lsb_one;
                        if (!lsb_one) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            st_nx       = SEQ;
                            rem_nx      = id_instr[7:0] & ~lsb_bit;
                            off_nx      = 3'd1;
                            is_store_nx = (opcode == OP_SM);
                        end
                    end
                end
            end
        end else begin
            // SM reads the register it stores, so a load in EX writing it must drain first.
            if (is_store && ex_is_load && (ex_rd == lsb_idx)) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                id_ex_en     = 1'b1;
                seq_active   = 1'b1;
                seq_rf_addr  = lsb_idx;
                seq_offset   = offset;
                seq_is_store = is_store;
                seq_last     = lsb_one;
                rem_nx       = rem_mask & ~lsb_bit;
                off_nx       = offset + 3'd1;
                if (lsb_one) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    st_nx       = IDLE;
                    off_nx      = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            rem_mask <= 8'd0;
            offset   <= 3'd0;
            is_store <= 1'b0;
        end else begin
            st       <= st_nx;
            rem_mask <= rem_nx;
            offset   <= off_nx;
            is_store <= is_store_nx;
        end
    end

`else

    logic unused_seq_bits;

    assign enc_in          = id_instr[7:0];
    assign unused_seq_bits = ^{id_instr[11:0], lsb_idx, lsb_bit, lsb_one, clk};

    assign seq_active   = 1'b0;
    assign seq_rf_addr  = '0;
    assign seq_offset   = 3'd0;
    assign seq_is_store = 1'b0;
    assign seq_last     = 1'b0;

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        illegal_instr = 1'b0;

        if (!rst || mem_stall) begin
            pc_en = 1'b0;
        end else if (ex_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (src_hit) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            // Without the sequencer LM/SM are squashed to a NOP and trapped.
            if (is_lmsm) begin
                id_ex_flush   = 1'b1;
                illegal_instr = 1'b1;
            end
        end
    end

`endif

endmodule
